mux_sel_arbiter: RTL and testbench

- Upstream control stage for the 4:1 data-select mux. It generates the 2-bit select code that drives the mux `sel_in`.
- Four requesters compete for the mux output.
- The arbiter grants one requester and holds the select code stable for the whole transfer. It then releases and re-arbitrates, with a guaranteed idle gap so the downstream mux never switches while a grant is valid.
- Arbitration policy is parameter-selected: round-robin or fixed priority.

---
 rtl/mux_sel_pkg.sv | 24 ++
 rtl/mux_sel_arbiter_rr_pick4.sv | 39 +++
 rtl/mux_sel_arbiter.sv | 127 ++++++++++++
 tb/tb_mux_sel_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_sel_pkg.sv
// -----------------------------------------------------------------------------
// mux_sel_pkg
// Shared definitions for the 4:1 data-select mux control path.
//   arbState_e   : arbiter state (IDLE waits for requests, GRANT holds a winner)
//   MODE_RR      : round-robin arbitration policy selector value
//   MODE_FIXED   : fixed-priority policy selector value (requester 0 highest)
//   muxSel_t     : 2-bit select code, the same encoding the mux sel_in expects
//   HOLD_CNT_MAX : ceiling of the grant hold counter
// -----------------------------------------------------------------------------
package mux_sel_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arbState_e;

   localparam int MODE_RR    = 0;
   localparam int MODE_FIXED = 1;

   typedef logic [1:0] muxSel_t;

   localparam logic [7:0] HOLD_CNT_MAX = 8'd255;

endpackage

// File: rtl/mux_sel_arbiter_rr_pick4.sv
// -----------------------------------------------------------------------------
// rr_pick4
// Combinational 4-way priority pick with a rotating start position. The search
// begins at ptr_i and walks upward, wrapping 3 -> 0; the first set request wins.
// Tying ptr_i to zero turns it into a plain lowest-index-first priority pick.
// Ports:
//   req_i    : request vector, bit i is requester i
//   ptr_i    : index where the search starts
//   idx_o    : index of the winning requester (don't care when anyReq_o is low)
//   anyReq_o : at least one request bit is set
// -----------------------------------------------------------------------------
module rr_pick4
   import mux_sel_pkg::*;
(
   input  logic [3:0] req_i,
   input  muxSel_t    ptr_i,
   output muxSel_t    idx_o,
   output logic       anyReq_o
);

   logic [3:0] rotReq;
   muxSel_t    offset;

   // Rotate the request vector so the start position lands on bit 0, find the
   // lowest set bit of the rotated copy, then add the start position back on.
   // The 2-bit add wraps naturally, which gives the 3 -> 0 wrap for free.
   always_comb begin
      rotReq   = 4'({req_i, req_i} >> ptr_i);
      offset   = 2'd0;
      for (int k = 3; k >= 0; k--) begin
         if (rotReq[k]) begin
            offset = 2'(k);
         end
      end
      idx_o    = ptr_i + offset;
      anyReq_o = |req_i;
   end

endmodule

// File: rtl/mux_sel_arbiter.sv
// -----------------------------------------------------------------------------
// mux_sel_arbiter
// Upstream control stage for the 4:1 data-select mux. Picks one of four
// requesters, holds the select code frozen for the whole transfer, then drops
// the grant for at least one cycle before re-arbitrating so the mux never
// switches under a valid grant.
// Parameters:
//   MODE     : MODE_RR (round-robin) or MODE_FIXED (requester 0 highest)
//   MAX_HOLD : cycles a grant may last before forced release, 0 = unlimited
// Ports:
//   clk_in      : clock, rising edge
//   rst_n_in    : synchronous active-low reset
//   req_in      : request vector, bit i selects mux input i
//   done_in     : current transfer complete (only looked at while granting)
//   sel_out     : select code to the mux sel_in, stable while valid_out is high
//   gnt_out     : one-hot grant, zero when no grant is active
//   valid_out   : grant active
//   timeout_out : one-cycle pulse when a grant was cut off by MAX_HOLD
// -----------------------------------------------------------------------------
module mux_sel_arbiter
   import mux_sel_pkg::*;
#(
   parameter int MODE     = MODE_RR,
   parameter int MAX_HOLD = 16
) (
   input  logic       clk_in,
   input  logic       rst_n_in,
   input  logic [3:0] req_in,
   input  logic       done_in,
   output logic [1:0] sel_out,
   output logic [3:0] gnt_out,
   output logic       valid_out,
   output logic       timeout_out
);

   // Counter value seen during the last permitted grant cycle.
   localparam logic [7:0] HOLD_LAST = 8'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
   localparam logic       HOLD_EN   = (MAX_HOLD != 0);

   arbState_e  state_q;
   muxSel_t    sel_q;
   muxSel_t    ptr_q;
   logic [3:0] gnt_q;
   logic       valid_q;
   logic       timeout_q;
   logic [7:0] holdCnt_q;
   logic [7:0] holdCnt_d;

   muxSel_t    pickPtr;
   muxSel_t    winner;
   logic       anyReq;
   logic       reqLost;
   logic       holdExpired;
   logic       releaseNow;
   logic       timeoutOnly;

   // Fixed priority is just the rotating pick with the start pinned at zero.
   assign pickPtr = (MODE == MODE_FIXED) ? 2'd0 : ptr_q;

   rr_pick4 uPick (
      .req_i    (req_in),
      .ptr_i    (pickPtr),
      .idx_o    (winner),
      .anyReq_o (anyReq)
   );

   // Release decision for the grant currently held. Any of the three causes is
   // enough, and they all collapse into one release; the timeout flag is only
   // raised when the hold limit is the sole reason the grant is ending.
   always_comb begin
      reqLost     = ~req_in[sel_q];
      holdExpired = HOLD_EN && (holdCnt_q == HOLD_LAST);
      releaseNow  = done_in | reqLost | holdExpired;
      timeoutOnly = holdExpired & ~done_in & ~reqLost;
      holdCnt_d   = (holdCnt_q == HOLD_CNT_MAX) ? holdCnt_q : holdCnt_q + 8'd1;
   end

   // Arbiter FSM with every output registered. Leaving GRANT always lands in
   // IDLE for at least one cycle, which is what guarantees the gap between
   // grants. sel_q is only written on entry to GRANT, so it never moves while
   // idle or while a grant is valid.
   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         state_q   <= IDLE;
         sel_q     <= 2'd0;
         gnt_q     <= 4'b0000;
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
         ptr_q     <= 2'd0;
         holdCnt_q <= 8'd0;
      end else begin
         timeout_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (anyReq) begin
                  state_q   <= GRANT;
                  sel_q     <= winner;
                  gnt_q     <= 4'b0001 << winner;
                  valid_q   <= 1'b1;
                  holdCnt_q <= 8'd0;
               end
            end
            GRANT: begin
               holdCnt_q <= holdCnt_d;
               if (releaseNow) begin
                  state_q   <= IDLE;
                  gnt_q     <= 4'b0000;
                  valid_q   <= 1'b0;
                  timeout_q <= timeoutOnly;
                  if (MODE == MODE_RR) begin
                     ptr_q <= sel_q + 2'd1;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign sel_out     = sel_q;
   assign gnt_out     = gnt_q;
   assign valid_out   = valid_q;
   assign timeout_out = timeout_q;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux_sel_arbiter
// Drives four arbiter instances (different MODE / MAX_HOLD) from shared
// stimulus and compares each against its own behavioural model every cycle.
// Directed vectors and hand-written sequences pin down rotation, starvation,
// timeout, coincident release and reset-during-grant behaviour.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mux_sel_arbiter;

   localparam int NUM_DUT = 4;
   localparam int DUT_MODE [NUM_DUT] = '{0, 1, 0, 1};
   localparam int DUT_HOLD [NUM_DUT] = '{4, 16, 1, 0};

   logic       clock;
   logic       rstN;
   logic [3:0] req;
   logic       done;

   logic [1:0] selO   [NUM_DUT];
   logic [3:0] gntO   [NUM_DUT];
   logic       validO [NUM_DUT];
   logic       toutO  [NUM_DUT];

   int checks;
   int failures;

   // Abstract view of one arbiter: who owns the mux, how many grant cycles
   // have already elapsed, and where the round-robin search would start.
   typedef struct {
      int mode;
      int maxHold;
      bit busy;
      int owner;
      int held;
      int rrStart;
      int lastSel;
      bit tPulse;
   } refModel_t;

   refModel_t model [NUM_DUT];

   typedef struct {
      bit         rstN;
      logic [3:0] req;
      bit         done;
      logic [1:0] sel;
      logic [3:0] gnt;
      bit         valid;
      bit         tout;
   } vector_t;

   vector_t vecs [$];

   mux_sel_arbiter #(.MODE(0), .MAX_HOLD(4)) dut0 (
      .clk_in(clock), .rst_n_in(rstN), .req_in(req), .done_in(done),
      .sel_out(selO[0]), .gnt_out(gntO[0]), .valid_out(validO[0]), .timeout_out(toutO[0]));
   mux_sel_arbiter #(.MODE(1), .MAX_HOLD(16)) dut1 (
      .clk_in(clock), .rst_n_in(rstN), .req_in(req), .done_in(done),
      .sel_out(selO[1]), .gnt_out(gntO[1]), .valid_out(validO[1]), .timeout_out(toutO[1]));
   mux_sel_arbiter #(.MODE(0), .MAX_HOLD(1)) dut2 (
      .clk_in(clock), .rst_n_in(rstN), .req_in(req), .done_in(done),
      .sel_out(selO[2]), .gnt_out(gntO[2]), .valid_out(validO[2]), .timeout_out(toutO[2]));
   mux_sel_arbiter #(.MODE(1), .MAX_HOLD(0)) dut3 (
      .clk_in(clock), .rst_n_in(rstN), .req_in(req), .done_in(done),
      .sel_out(selO[3]), .gnt_out(gntO[3]), .valid_out(validO[3]), .timeout_out(toutO[3]));

   // Free-running 10 ns clock.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // One clock edge of the abstract arbiter: reset wipes everything, an idle
   // arbiter picks the first requester in search order, a busy one counts the
   // cycle and lets go on done, lost request or reaching the hold limit.
   function automatic refModel_t stepModel(refModel_t m, bit r, logic [3:0] rq, bit d);
      refModel_t n = m;
      if (!r) begin
         n.busy    = 1'b0;
         n.owner   = 0;
         n.held    = 0;
         n.rrStart = 0;
         n.lastSel = 0;
         n.tPulse  = 1'b0;
      end else if (!m.busy) begin
         n.tPulse = 1'b0;
         if (rq != 4'b0000) begin
            int  start = (m.mode == 1) ? 0 : m.rrStart;
            bit  found = 1'b0;
            for (int k = 0; k < 4; k++) begin
               int idx = (start + k) % 4;
               if (!found && rq[idx]) begin
                  found     = 1'b1;
                  n.busy    = 1'b1;
                  n.owner   = idx;
                  n.lastSel = idx;
                  n.held    = 0;
               end
            end
         end
      end else begin
         bit stillWanted = rq[m.owner];
         bit timedOut    = (m.maxHold != 0) && (m.held + 1 >= m.maxHold);
         if (d || !stillWanted || timedOut) begin
            n.busy   = 1'b0;
            n.tPulse = timedOut && !d && stillWanted;
            if (m.mode == 0) n.rrStart = (m.owner + 1) % 4;
         end else begin
            n.held   = m.held + 1;
            n.tPulse = 1'b0;
         end
      end
      return n;
   endfunction

   function automatic logic [7:0] expectedOf(refModel_t m);
      logic [3:0] g;
      g = m.busy ? 4'(1 << m.owner) : 4'b0000;
      return {2'(m.lastSel), g, m.busy, m.tPulse};
   endfunction

   // Compare one instance's outputs against a packed {sel, gnt, valid, timeout}.
   task automatic checkOutput(input string tag, input int inst, input logic [7:0] expected);
      logic [7:0] actual;
      actual = {selO[inst], gntO[inst], validO[inst], toutO[inst]};
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s dut%0d t=%0t: got sel=%0d gnt=%b valid=%b timeout=%b, expected sel=%0d gnt=%b valid=%b timeout=%b",
                  tag, inst, $time, actual[7:6], actual[5:2], actual[1], actual[0],
                  expected[7:6], expected[5:2], expected[1], expected[0]);
      end
   endtask

   task automatic expectInst(input string tag, input int inst, input logic [1:0] s,
                             input logic [3:0] g, input logic v, input logic t);
      checkOutput(tag, inst, {s, g, v, t});
   endtask

   // Apply one cycle of inputs, let the edge happen, then advance every model
   // and compare every instance a little after the edge.
   task automatic applyStimulus(input bit r, input logic [3:0] rq, input bit d);
      rstN = r;
      req  = rq;
      done = d;
      @(posedge clock);
      #1;
      for (int i = 0; i < NUM_DUT; i++) begin
         model[i] = stepModel(model[i], r, rq, d);
         checkOutput("model", i, expectedOf(model[i]));
      end
   endtask

   task automatic addVec(input bit r, input logic [3:0] rq, input bit d, input logic [1:0] s,
                         input logic [3:0] g, input bit v, input bit t);
      vector_t vv;
      vv.rstN = r; vv.req = rq; vv.done = d;
      vv.sel = s; vv.gnt = g; vv.valid = v; vv.tout = t;
      vecs.push_back(vv);
   endtask

   // Main test sequence.
   initial begin
      checks   = 0;
      failures = 0;
      rstN     = 1'b0;
      req      = 4'b0000;
      done     = 1'b0;
      for (int i = 0; i < NUM_DUT; i++) begin
         model[i].mode    = DUT_MODE[i];
         model[i].maxHold = DUT_HOLD[i];
         model[i].busy    = 1'b0;
         model[i].owner   = 0;
         model[i].held    = 0;
         model[i].rrStart = 0;
         model[i].lastSel = 0;
         model[i].tPulse  = 1'b0;
      end

      // Vectors for dut0 (round-robin, MAX_HOLD=4): reset with all requests,
      // a full rotation with done pulsed, then a timeout and re-grant.
      addVec(0, 4'b1111, 0, 2'd0, 4'b0000, 0, 0);
      addVec(0, 4'b1111, 0, 2'd0, 4'b0000, 0, 0);
      addVec(1, 4'b1111, 0, 2'd0, 4'b0001, 1, 0);
      addVec(1, 4'b1111, 1, 2'd0, 4'b0000, 0, 0);
      addVec(1, 4'b1111, 0, 2'd1, 4'b0010, 1, 0);
      addVec(1, 4'b1111, 1, 2'd1, 4'b0000, 0, 0);
      addVec(1, 4'b1111, 0, 2'd2, 4'b0100, 1, 0);
      addVec(1, 4'b1111, 1, 2'd2, 4'b0000, 0, 0);
      addVec(1, 4'b1111, 0, 2'd3, 4'b1000, 1, 0);
      addVec(1, 4'b1111, 1, 2'd3, 4'b0000, 0, 0);
      addVec(1, 4'b1111, 0, 2'd0, 4'b0001, 1, 0);
      addVec(1, 4'b1111, 1, 2'd0, 4'b0000, 0, 0);
      addVec(1, 4'b0100, 0, 2'd2, 4'b0100, 1, 0);
      addVec(1, 4'b0100, 0, 2'd2, 4'b0100, 1, 0);
      addVec(1, 4'b0100, 0, 2'd2, 4'b0100, 1, 0);
      addVec(1, 4'b0100, 0, 2'd2, 4'b0100, 1, 0);
      addVec(1, 4'b0100, 0, 2'd2, 4'b0000, 0, 1);
      addVec(1, 4'b0100, 0, 2'd2, 4'b0100, 1, 0);
      addVec(1, 4'b0100, 1, 2'd2, 4'b0000, 0, 0);

      $display("[TB] directed vectors: %0d", vecs.size());
      foreach (vecs[i]) begin
         applyStimulus(vecs[i].rstN, vecs[i].req, vecs[i].done);
         expectInst("vector", 0, vecs[i].sel, vecs[i].gnt, vecs[i].valid, vecs[i].tout);
      end

      // Fixed priority on dut1: requester 1 always beats requester 3 until it
      // stops asking.
      $display("[TB] fixed priority starvation");
      applyStimulus(0, 4'b0000, 0);
      for (int n = 0; n < 3; n++) begin
         applyStimulus(1, 4'b1010, 0);
         expectInst("fixedGrant", 1, 2'd1, 4'b0010, 1, 0);
         applyStimulus(1, 4'b1010, 1);
         expectInst("fixedGap", 1, 2'd1, 4'b0000, 0, 0);
      end
      applyStimulus(1, 4'b1000, 0);
      expectInst("fixedDrop", 1, 2'd3, 4'b1000, 1, 0);
      applyStimulus(1, 4'b1000, 1);

      // Coincident release on dut0: done, request drop and hold limit all on
      // the fourth grant cycle give one plain release and one pointer step.
      $display("[TB] coincident release");
      applyStimulus(0, 4'b0000, 0);
      applyStimulus(1, 4'b0001, 0);
      expectInst("simGrant", 0, 2'd0, 4'b0001, 1, 0);
      for (int n = 0; n < 3; n++) begin
         applyStimulus(1, 4'b0001, 0);
         expectInst("simHold", 0, 2'd0, 4'b0001, 1, 0);
      end
      applyStimulus(1, 4'b0000, 1);
      expectInst("simRelease", 0, 2'd0, 4'b0000, 0, 0);
      applyStimulus(1, 4'b1111, 0);
      expectInst("simPtrStep", 0, 2'd1, 4'b0010, 1, 0);
      applyStimulus(1, 4'b1111, 1);

      // Reset during a grant to requester 3 on dut0: drops at once and the
      // round-robin start returns to zero.
      $display("[TB] reset mid-grant");
      applyStimulus(1, 4'b1000, 0);
      expectInst("midGrant", 0, 2'd3, 4'b1000, 1, 0);
      applyStimulus(0, 4'b1000, 0);
      expectInst("midReset", 0, 2'd0, 4'b0000, 0, 0);
      applyStimulus(1, 4'b1001, 0);
      expectInst("postReset", 0, 2'd0, 4'b0001, 1, 0);

      // Random traffic with sticky requests, occasional done and rare resets.
      $display("[TB] random traffic");
      begin
         logic [3:0] rq;
         rq = 4'b0000;
         for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 9) < 3) rq = 4'($urandom_range(0, 15));
            applyStimulus($urandom_range(0, 59) != 0, rq, $urandom_range(0, 5) == 0);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
